// File: rtl/mips32_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// mips32_fetch_stage_if : imem bus, ID handshake and redirect/halt bundle
// Revision 1.0
// ============================================================================
interface mips32_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_npc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              wb_halt;
  logic              halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_npc, halted,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready, br_taken, br_target, wb_halt
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_npc, halted,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready, br_taken, br_target, wb_halt
  );
endinterface
`default_nettype wire

// File: rtl/mips32_fetch_stage.sv
`default_nettype none
// ============================================================================
// mips32_fetch_stage : MIPS32 IF stage with prefetch FIFO and branch squash
// Revision 1.0
// ============================================================================
module mips32_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic            clk1,
  input  wire logic            rst,
  mips32_fetch_stage_if.master fs
);
  localparam int                C_PTR_W   = $clog2(DEPTH);
  localparam int                C_CNT_W   = $clog2(DEPTH + 1);
  localparam logic [C_CNT_W:0]  C_DEPTH   = (C_CNT_W + 1)'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_MAX_OUT = C_CNT_W'(MAX_OUT);
  localparam logic [5:0]        C_OP_HLT  = 6'h3F;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [C_CNT_W-1:0] r_out;
  logic [C_CNT_W-1:0] r_drop;
  logic [C_CNT_W-1:0] r_count;
  logic [C_PTR_W-1:0] r_wr;
  logic [C_PTR_W-1:0] r_rd;
  logic               r_hlt_seen;
  logic               r_halted;
  logic [31:0]        r_mem_instr [DEPTH];
  logic [ADDR_W-1:0]  r_mem_npc   [DEPTH];

  logic w_rsp_keep;
  logic w_rsp_hlt;
  logic w_credit;
  logic w_req;
  logic w_gnt;
  logic w_valid;
  logic w_pop;

  // An arriving HLT blocks issue in the same cycle so nothing past it is requested.
  assign w_rsp_keep = fs.imem_rvalid & (r_drop == '0) & ~fs.br_taken;
  assign w_rsp_hlt  = w_rsp_keep & (fs.imem_rdata[31:26] == C_OP_HLT);
  assign w_credit   = ({1'b0, r_count} + {1'b0, r_out} - {1'b0, r_drop}) < C_DEPTH;
  assign w_req      = ~rst & ~r_halted & ~r_hlt_seen & ~fs.br_taken & ~w_rsp_hlt &
                      (r_out < C_MAX_OUT) & w_credit;
  assign w_gnt      = w_req & fs.imem_gnt;
  assign w_valid    = ~rst & (r_count != '0) & ~fs.br_taken & ~r_halted;
  assign w_pop      = w_valid & fs.if_ready;

  assign fs.imem_req  = w_req;
  assign fs.imem_addr = r_pc;
  assign fs.if_valid  = w_valid;
  assign fs.if_instr  = r_mem_instr[r_rd];
  assign fs.if_npc    = r_mem_npc[r_rd];
  assign fs.halted    = r_halted;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_hlt_seen <= 1'b0;
      r_halted   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_npc[i]   <= '0;
      end
    end else begin
      if (fs.wb_halt) begin
        r_halted <= 1'b1;
      end
      if (fs.br_taken) begin
        // Everything still in flight after this cycle's response is stale.
        r_pc       <= fs.br_target;
        r_resp_pc  <= fs.br_target;
        r_count    <= '0;
        r_wr       <= '0;
        r_rd       <= '0;
        r_hlt_seen <= 1'b0;
        r_out      <= r_out - C_CNT_W'(fs.imem_rvalid);
        r_drop     <= r_out - C_CNT_W'(fs.imem_rvalid);
      end else begin
        if (w_gnt) begin
          r_pc <= r_pc + 1'b1;
        end
        r_out <= r_out + C_CNT_W'(w_gnt) - C_CNT_W'(fs.imem_rvalid);
        if (fs.imem_rvalid && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
        if (w_rsp_keep) begin
          r_mem_instr[r_wr] <= fs.imem_rdata;
          r_mem_npc[r_wr]   <= r_resp_pc + 1'b1;
          r_wr              <= r_wr + 1'b1;
          r_resp_pc         <= r_resp_pc + 1'b1;
        end
        if (w_rsp_hlt) begin
          r_hlt_seen <= 1'b1;
        end
        if (w_pop) begin
          r_rd <= r_rd + 1'b1;
        end
        r_count <= r_count + C_CNT_W'(w_rsp_keep) - C_CNT_W'(w_pop);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_mips32_fetch_stage : directed + random bench against an instruction-stream model
// Revision 1.0
// ============================================================================
module tb_mips32_fetch_stage;
  localparam int MAX_OUT = 2;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  mips32_fetch_stage_if #(.ADDR_W(32)) bus ();
  mips32_fetch_stage_if #(.ADDR_W(32)) bus2 ();

  mips32_fetch_stage #(.ADDR_W(32), .DEPTH(4), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0))
    dut (.clk1(clk1), .rst(rst), .fs(bus));
  mips32_fetch_stage #(.ADDR_W(32), .DEPTH(4), .MAX_OUT(MAX_OUT), .RESET_PC(32'hFFFF_FFFF))
    dut_wrap (.clk1(clk1), .rst(rst), .fs(bus2));

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  rd_t         pend[$];
  logic [31:0] pend2[$];
  logic [31:0] prog [0:8] = '{32'h2820000a, 32'h20010005, 32'h20020003, 32'h00221820,
                              32'h00622025, 32'h20840001, 32'h00842820, 32'h00a13025,
                              32'hfc000000};

  int          checks = 0;
  int          errors = 0;
  int          cyc, last_due, lat_min, lat_max;
  int          grants, pops;
  logic [31:0] exp_pop, exp_iss, first_npc;
  bit          got_first, halted_m;
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'd9) return prog[a[3:0]];
    w = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    if (w[31:26] == 6'h3F) w[26] = 1'b0;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_phase();
    grants = 0; pops = 0; got_first = 0; first_npc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.if_ready = 0;
    bus.br_taken = 0; bus.br_target = '0; bus.wb_halt = 0;
    bus2.imem_gnt = 0; bus2.imem_rvalid = 0; bus2.imem_rdata = '0; bus2.if_ready = 0;
    bus2.br_taken = 0; bus2.br_target = '0; bus2.wb_halt = 0;
    pend.delete(); pend2.delete();
    @(posedge clk1); #1; @(posedge clk1); #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.if_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_npc", bus.if_npc, 32'h0);
    chk("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFFF);
    rst = 1'b0;
    cyc = 0; last_due = -1; exp_pop = '0; exp_iss = '0; halted_m = 0;
    clear_phase();
  endtask

  // One pipeline cycle: memory model drives responses, model checks grants and pops.
  task automatic cycle(input bit gnt, input bit rdy, input bit br, input logic [31:0] tgt,
                       input bit wbh);
    bit  rv;
    int  due;
    rd_t e;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_gnt = gnt; bus.if_ready = rdy; bus.br_taken = br; bus.br_target = tgt;
    bus.wb_halt = wbh; bus.imem_rvalid = rv;
    bus.imem_rdata = rv ? memword(pend[0].addr) : 32'h0;
    #1;
    s_req = bus.imem_req; s_valid = bus.if_valid; s_addr = bus.imem_addr;
    chk("halted", bus.halted, halted_m);
    if (halted_m || br) begin
      chk("req_off", s_req, 0);
      chk("valid_off", s_valid, 0);
    end
    if (s_req && gnt) begin
      chk("iss_addr", s_addr, exp_iss);
      chk("max_out", pend.size() < MAX_OUT, 1);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr = s_addr; e.due = due;
      pend.push_back(e);
      exp_iss++; grants++;
    end
    if (s_valid && rdy) begin
      chk("pop_npc", bus.if_npc, exp_pop + 32'd1);
      chk("pop_instr", bus.if_instr, memword(exp_pop));
      if (!got_first) first_npc = bus.if_npc;
      got_first = 1;
      exp_pop++; pops++;
    end
    if (rv) void'(pend.pop_front());
    if (br) begin
      exp_pop = tgt; exp_iss = tgt;
    end
    if (wbh) halted_m = 1;
    @(posedge clk1); #1;
    cyc++;
  endtask

  int w_grants, w_pops;

  initial begin
    // Streaming program with 1-cycle memory
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1, 1, 0, 0, 0); chk("first_req", s_req, 1);
    cycle(1, 1, 0, 0, 0); chk("lat_t1_valid", s_valid, 0);
    cycle(1, 1, 0, 0, 0); chk("lat_t2_valid", s_valid, 1);
    repeat (25) cycle(1, 1, 0, 0, 0);
    chk("stream_grants", grants, 9);
    chk("stream_pops", pops, 9);
    chk("stream_hlt_req", s_req, 0);

    // Backpressure from reset
    do_reset();
    repeat (10) cycle(1, 0, 0, 0, 0);
    chk("bp_req_off", s_req, 0);
    chk("bp_grants", grants, 4);
    chk("bp_valid", s_valid, 1);
    repeat (30) cycle(1, 1, 0, 0, 0);
    chk("bp_pops", pops, 9);
    chk("bp_grants_all", grants, 9);

    // Redirect with two reads in flight, 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 32'h20, 0);
    clear_phase();
    repeat (20) cycle(1, 1, 0, 0, 0);
    chk("rd2_first_npc", first_npc, 32'h21);
    chk("rd2_progress", pops >= 5, 1);

    // Redirect coinciding with a response and a ready head
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (5) cycle(1, 1, 0, 0, 0);
    chk("pre_br_valid", s_valid, 1);
    cycle(1, 1, 1, 32'h40, 0);
    chk("br_cycle_valid", s_valid, 0);
    clear_phase();
    repeat (10) cycle(1, 1, 0, 0, 0);
    chk("br_coinc_npc", first_npc, 32'h41);

    // HLT throttle, redirect resume, then WB halt
    do_reset();
    repeat (20) cycle(1, 1, 0, 0, 0);
    chk("hlt_grants", grants, 9);
    chk("hlt_req_off", s_req, 0);
    cycle(1, 1, 1, 32'h3, 0);
    clear_phase();
    repeat (20) cycle(1, 1, 0, 0, 0);
    chk("hlt_resume_npc", first_npc, 32'h4);
    chk("hlt_resume_grants", grants, 6);
    cycle(1, 1, 0, 0, 1);
    repeat (8) cycle(1, 1, 0, 0, 0);
    chk("halted_set", bus.halted, 1);
    cycle(1, 1, 1, 32'h5, 0);
    repeat (5) cycle(1, 1, 0, 0, 0);
    chk("halted_req", s_req, 0);

    // Randomized traffic
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      bit g, r, b;
      g = ($urandom_range(99) < 75);
      r = ($urandom_range(99) < 65);
      b = ($urandom_range(99) < 3);
      cycle(g, r, b, 32'($urandom_range(63)), 0);
    end
    chk("rnd_progress", pops > 100, 1);
    cycle(1, 1, 1, 32'h30, 1);
    cycle(1, 1, 0, 0, 0);
    chk("halt_br_addr", s_addr, 32'h30);
    chk("halt_br_halted", bus.halted, 1);

    // PC wrap on a second instance
    do_reset();
    w_grants = 0; w_pops = 0;
    for (int i = 0; i < 6; i++) begin
      bit rv2;
      rv2 = (pend2.size() > 0);
      bus2.imem_gnt = 1; bus2.if_ready = 1; bus2.imem_rvalid = rv2;
      bus2.imem_rdata = rv2 ? memword(pend2[0]) : 32'h0;
      #1;
      if (bus2.imem_req) begin
        if (w_grants == 0) chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFF);
        if (w_grants == 1) chk("wrap_addr1", bus2.imem_addr, 32'h0);
        pend2.push_back(bus2.imem_addr);
        w_grants++;
      end
      if (bus2.if_valid) begin
        if (w_pops == 0) begin
          chk("wrap_npc", bus2.if_npc, 32'h0);
          chk("wrap_instr", bus2.if_instr, memword(32'hFFFF_FFFF));
        end
        w_pops++;
      end
      if (rv2) void'(pend2.pop_front());
      @(posedge clk1); #1;
    end
    chk("wrap_grants", w_grants >= 2, 1);
    chk("wrap_pops", w_pops >= 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
